climate_actuator_fsm: RTL and testbench
=======================================

# climate_actuator_fsm

Downstream consumer of the UART-configured thresholds. Takes periodic signed temperature samples (greenhouse, solar collector, ambient, geothermal) plus a 16-bit light level, and runs a hysteresis state machine with minimum-dwell timing. It selects one heating or cooling source and drives the fan, vent and pump enables for the greenhouse.

## Interface
- MIN_DWELL, 16'd50000: cycles a new state is held before another decision is allowed (≥1).
- HYST, 8'sd2: exit hysteresis in °C, signed.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sample_valid  in  1  one-cycle strobe; all sensor inputs are valid this cycle
- greenhouse_temp, solar_temp, ambient_temp, geothermal_temp  in  8 each  signed °C
- light_level  in  16  unsigned light reading
- solar_th  in  16  minimum light level for solar heating
- solar_heatup_th, solar_cooldown_th, greenhouse_heatup_th, greenhouse_cooldown_th, ambient_heatup_th, ambient_cooldown_th, geothermal_heatup_th, geothermal_cooldown_th  in  8 each  signed thresholds
- state  out  3  IDLE=0, HEAT_SOLAR=1, HEAT_GEO=2, COOL_AMBIENT=3, COOL_GEO=4
- fan_en, vent_open, solar_pump_en, geo_pump_en  out  1 each  actuator enables
- busy  out  1  dwell timer non-zero
- change  out  1  one-cycle pulse on every state transition
- fault  out  1  present only with CLIMATE_FAULT_EN

## Operation
- Capture: all temperatures and light_level are registered on the sample_valid edge. Thresholds are read live at evaluation time.
- Evaluation: runs in the cycle after a capture. It is skipped when busy=1, and that sample is discarded.
- Compares: all signed, sign-extended to 9 bits. `greenhouse_heatup_th+HYST` and `greenhouse_cooldown_th-HYST` are computed in 9 bits with no wrap.
- Predicates:
  - heat_dem: gh < greenhouse_heatup_th
  - cool_dem: gh > greenhouse_cooldown_th
  - solar_ok: light_level ≥ solar_th and solar > solar_heatup_th and solar > gh
  - geoh_ok: geo > geothermal_heatup_th and geo > gh
  - amb_ok: amb < ambient_cooldown_th and amb < gh
  - geoc_ok: geo < geothermal_cooldown_th and geo < gh
- ambient_heatup_th and solar_cooldown_th are accepted but unused (reserved).
- IDLE transitions:
  - heat_dem and solar_ok → HEAT_SOLAR
  - else heat_dem and geoh_ok → HEAT_GEO
  - else cool_dem and amb_ok → COOL_AMBIENT
  - else cool_dem and geoc_ok → COOL_GEO
  - else stay. Heat takes priority over cool if thresholds are misordered.
- HEAT_SOLAR → IDLE when gh ≥ greenhouse_heatup_th+HYST or !solar_ok. HEAT_GEO uses the same rule with geoh_ok.
- COOL_AMBIENT → IDLE when gh ≤ greenhouse_cooldown_th−HYST or !amb_ok. COOL_GEO uses the same rule with geoc_ok.
- No direct source-to-source transition; every change passes through IDLE.
- Outputs (registered, decoded from next state):
  - fan_en = state≠IDLE
  - solar_pump_en = HEAT_SOLAR
  - geo_pump_en = HEAT_GEO or COOL_GEO
  - vent_open = COOL_AMBIENT
- Dwell: on every transition, including to IDLE, a 16-bit counter loads MIN_DWELL. It decrements each cycle to 0, and busy = (counter≠0).

## Timing
- Reset: state=IDLE; all enables, busy, change and fault = 0; counter=0; captured samples=0.
- Latency: sample_valid sampled at edge E0 → state, outputs and change update at E1. change is high for exactly the cycle after E1. busy is high from E1 for MIN_DWELL cycles.
- sample_valid during the evaluation cycle: the new sample overwrites the capture and is evaluated at the next edge. No queueing.
- Counter is reloaded on a transition even if it is already non-zero; this only occurs under fault.
- rst mid-dwell or mid-state: immediate return to reset values at the next edge.

## Configuration
- CLIMATE_FAULT_EN defined:
  - Any captured temperature equal to −128 (8'h80, sensor fault code) forces state IDLE at the evaluation edge, ignoring busy and reloading dwell.
  - fault=1 until a sample with no −128 value is evaluated.
- CLIMATE_FAULT_EN undefined: −128 is treated as an ordinary temperature, and the fault port is absent.

## Test plan
Bench uses MIN_DWELL=4, HYST=2, thresholds 35/16 and solar_th=2550.
- Reset → state=0, all enables=0, busy=0, change=0.
- gh=10, solar=40, light=3000, amb=5, geo=12 → state=1, solar_pump_en=1, fan_en=1, change pulse one cycle after E0.
- Same sample but light=2000, geo=20 → state=2, geo_pump_en=1.
- In HEAT_SOLAR after dwell, sample gh=17 → stay 1. Then gh=18 → state=0, all enables=0.
- gh=40, amb=30 → state=3, vent_open=1. Back in IDLE with amb=36, geo=20 → state=4, geo_pump_en=1. A second sample issued 2 cycles after a transition is ignored.
- CLIMATE_FAULT_EN: in state 1, sample with amb=−128 during busy → state=0, fault=1. Next clean sample → fault=0.

Source files
------------

// File: rtl/climate_actuator_fsm.sv
// climate_actuator_fsm: greenhouse heating/cooling source selector.
// Captures signed temperature samples and a light level, evaluates them one
// cycle later through a hysteresis state machine, and holds each new state for
// MIN_DWELL cycles before another decision is taken.
// Optional feature macro: CLIMATE_FAULT_EN (sensor fault code -128 forces IDLE
// and adds the fault output).
module climate_actuator_fsm #(
    parameter logic        [15:0] MIN_DWELL = 16'd50000,
    parameter logic signed [7:0]  HYST      = 8'sd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [7:0]  greenhouse_temp,
    input  logic signed [7:0]  solar_temp,
    input  logic signed [7:0]  ambient_temp,
    input  logic signed [7:0]  geothermal_temp,
    input  logic        [15:0] light_level,
    input  logic        [15:0] solar_th,
    input  logic signed [7:0]  solar_heatup_th,
    input  logic signed [7:0]  solar_cooldown_th,
    input  logic signed [7:0]  greenhouse_heatup_th,
    input  logic signed [7:0]  greenhouse_cooldown_th,
    input  logic signed [7:0]  ambient_heatup_th,
    input  logic signed [7:0]  ambient_cooldown_th,
    input  logic signed [7:0]  geothermal_heatup_th,
    input  logic signed [7:0]  geothermal_cooldown_th,
    output logic        [2:0]  state,
    output logic               fan_en,
    output logic               vent_open,
    output logic               solar_pump_en,
    output logic               geo_pump_en,
    output logic               busy,
    output logic               change
`ifdef CLIMATE_FAULT_EN
    ,
    output logic               fault
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HEAT_SOLAR = 3'd1,
        ST_HEAT_GEO   = 3'd2,
        ST_COOL_AMB   = 3'd3,
        ST_COOL_GEO   = 3'd4
    } state_t;

    state_t             r_state;
    logic        [15:0] r_cnt;
    logic               r_pend;
    logic               r_change;
    logic               r_fan;
    logic               r_vent;
    logic               r_solar_pump;
    logic               r_geo_pump;
    logic signed [7:0]  r_gh;
    logic signed [7:0]  r_sol;
    logic signed [7:0]  r_amb;
    logic signed [7:0]  r_geo;
    logic        [15:0] r_light;

    logic signed [8:0]  w_gh;
    logic signed [8:0]  w_sol;
    logic signed [8:0]  w_amb;
    logic signed [8:0]  w_geo;
    logic signed [8:0]  w_gh_heat_exit;
    logic signed [8:0]  w_gh_cool_exit;
    logic               w_heat_dem;
    logic               w_cool_dem;
    logic               w_solar_ok;
    logic               w_geoh_ok;
    logic               w_amb_ok;
    logic               w_geoc_ok;
    logic               w_eval;
    logic               w_reload;
    logic               w_trans;
    state_t             w_next;
    state_t             w_new;

    // Reserved thresholds: accepted on the interface, not used in any decision.
    logic               w_unused;
    assign w_unused = ^{ambient_heatup_th, solar_cooldown_th};

    function automatic logic signed [8:0] sx9(input logic [7:0] v);
        return {v[7], v};
    endfunction

    assign w_gh  = sx9(r_gh);
    assign w_sol = sx9(r_sol);
    assign w_amb = sx9(r_amb);
    assign w_geo = sx9(r_geo);

    // 9-bit exit thresholds so +/-HYST never wraps at the 8-bit limits.
    assign w_gh_heat_exit = sx9(greenhouse_heatup_th) + sx9(HYST);
    assign w_gh_cool_exit = sx9(greenhouse_cooldown_th) - sx9(HYST);

    assign w_heat_dem = w_gh < sx9(greenhouse_heatup_th);
    assign w_cool_dem = w_gh > sx9(greenhouse_cooldown_th);
    assign w_solar_ok = (r_light >= solar_th) && (w_sol > sx9(solar_heatup_th)) && (w_sol > w_gh);
    assign w_geoh_ok  = (w_geo > sx9(geothermal_heatup_th)) && (w_geo > w_gh);
    assign w_amb_ok   = (w_amb < sx9(ambient_cooldown_th)) && (w_amb < w_gh);
    assign w_geoc_ok  = (w_geo < sx9(geothermal_cooldown_th)) && (w_geo < w_gh);

    // A pending capture is only evaluated once the dwell timer has expired.
    assign w_eval = r_pend && (r_cnt == '0);

`ifdef CLIMATE_FAULT_EN
    logic w_fault_smp;
    logic r_fault;
    assign w_fault_smp = (r_gh == 8'h80) || (r_sol == 8'h80) ||
                         (r_amb == 8'h80) || (r_geo == 8'h80);
    assign fault       = r_fault;
`endif

    // Hysteresis decision from the current state and captured sample.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_heat_dem && w_solar_ok)      w_next = ST_HEAT_SOLAR;
                else if (w_heat_dem && w_geoh_ok)  w_next = ST_HEAT_GEO;
                else if (w_cool_dem && w_amb_ok)   w_next = ST_COOL_AMB;
                else if (w_cool_dem && w_geoc_ok)  w_next = ST_COOL_GEO;
            end
            ST_HEAT_SOLAR: if ((w_gh >= w_gh_heat_exit) || !w_solar_ok) w_next = ST_IDLE;
            ST_HEAT_GEO:   if ((w_gh >= w_gh_heat_exit) || !w_geoh_ok)  w_next = ST_IDLE;
            ST_COOL_AMB:   if ((w_gh <= w_gh_cool_exit) || !w_amb_ok)   w_next = ST_IDLE;
            ST_COOL_GEO:   if ((w_gh <= w_gh_cool_exit) || !w_geoc_ok)  w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Resolve the state taken at this edge, with the sensor-fault override first.
    always_comb begin
        w_new    = r_state;
        w_reload = 1'b0;
`ifdef CLIMATE_FAULT_EN
        if (r_pend && w_fault_smp) begin
            w_new    = ST_IDLE;
            w_reload = 1'b1;
        end else
`endif
        if (w_eval) begin
            w_new = w_next;
        end
    end

    assign w_trans = (w_new != r_state);

    // State, dwell timer, sample capture and actuator outputs decoded from the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_change     <= 1'b0;
            r_fan        <= 1'b0;
            r_vent       <= 1'b0;
            r_solar_pump <= 1'b0;
            r_geo_pump   <= 1'b0;
            r_gh         <= '0;
            r_sol        <= '0;
            r_amb        <= '0;
            r_geo        <= '0;
            r_light      <= '0;
`ifdef CLIMATE_FAULT_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            r_pend <= sample_valid;
            if (sample_valid) begin
                r_gh    <= greenhouse_temp;
                r_sol   <= solar_temp;
                r_amb   <= ambient_temp;
                r_geo   <= geothermal_temp;
                r_light <= light_level;
            end
            r_state  <= w_new;
            r_change <= w_trans;
            if (w_trans || w_reload) begin
                r_cnt <= MIN_DWELL;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            r_fan        <= (w_new != ST_IDLE);
            r_vent       <= (w_new == ST_COOL_AMB);
            r_solar_pump <= (w_new == ST_HEAT_SOLAR);
            r_geo_pump   <= (w_new == ST_HEAT_GEO) || (w_new == ST_COOL_GEO);
`ifdef CLIMATE_FAULT_EN
            if (r_pend && w_fault_smp) begin
                r_fault <= 1'b1;
            end else if (w_eval) begin
                r_fault <= 1'b0;
            end
`endif
        end
    end

    assign state         = r_state;
    assign fan_en        = r_fan;
    assign vent_open     = r_vent;
    assign solar_pump_en = r_solar_pump;
    assign geo_pump_en   = r_geo_pump;
    assign busy          = (r_cnt != '0);
    assign change        = r_change;

endmodule

// File: tb/tb_climate_actuator_fsm.sv
// Bench for climate_actuator_fsm: directed samples, an integer reference model
// of the climate rules checked on every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_climate_actuator_fsm;

    localparam logic [15:0] MD = 16'd4;
    localparam int DWELL     = 4;
    localparam int HY        = 2;
    localparam int SOLAR_TH  = 2550;
    localparam int TH_GH_UP  = 16;
    localparam int TH_GH_DN  = 35;
    localparam int TH_SOL_UP = 16;
    localparam int TH_SOL_DN = 35;
    localparam int TH_AMB_UP = 16;
    localparam int TH_AMB_DN = 35;
    localparam int TH_GEO_UP = 16;
    localparam int TH_GEO_DN = 35;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_valid = 1'b0;
    logic signed [7:0] gh = '0, sol = '0, amb = '0, geo = '0;
    logic [15:0] light = '0;
    logic [2:0] state;
    logic fan_en, vent_open, solar_pump_en, geo_pump_en, busy, change;
`ifdef CLIMATE_FAULT_EN
    logic fault;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    climate_actuator_fsm #(.MIN_DWELL(MD), .HYST(8'sd2)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .greenhouse_temp(gh), .solar_temp(sol), .ambient_temp(amb), .geothermal_temp(geo),
        .light_level(light), .solar_th(16'(SOLAR_TH)),
        .solar_heatup_th(8'(TH_SOL_UP)), .solar_cooldown_th(8'(TH_SOL_DN)),
        .greenhouse_heatup_th(8'(TH_GH_UP)), .greenhouse_cooldown_th(8'(TH_GH_DN)),
        .ambient_heatup_th(8'(TH_AMB_UP)), .ambient_cooldown_th(8'(TH_AMB_DN)),
        .geothermal_heatup_th(8'(TH_GEO_UP)), .geothermal_cooldown_th(8'(TH_GEO_DN)),
        .state(state), .fan_en(fan_en), .vent_open(vent_open),
        .solar_pump_en(solar_pump_en), .geo_pump_en(geo_pump_en),
        .busy(busy), .change(change)
`ifdef CLIMATE_FAULT_EN
        , .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: states are plain integers 0..4, sample values plain ints.
    int m_state = 0, m_cnt = 0, m_pend = 0, m_chg = 0, m_fault = 0;
    int c_gh = 0, c_sol = 0, c_amb = 0, c_geo = 0, c_light = 0;

    function automatic int model_next(input int s);
        bit heat   = c_gh < TH_GH_UP;
        bit cool   = c_gh > TH_GH_DN;
        bit sol_ok = (c_light >= SOLAR_TH) && (c_sol > TH_SOL_UP) && (c_sol > c_gh);
        bit gh_ok  = (c_geo > TH_GEO_UP) && (c_geo > c_gh);
        bit am_ok  = (c_amb < TH_AMB_DN) && (c_amb < c_gh);
        bit gc_ok  = (c_geo < TH_GEO_DN) && (c_geo < c_gh);
        bit h_exit = c_gh >= TH_GH_UP + HY;
        bit c_exit = c_gh <= TH_GH_DN - HY;
        case (s)
            0: begin
                if (heat && sol_ok) return 1;
                if (heat && gh_ok)  return 2;
                if (cool && am_ok)  return 3;
                if (cool && gc_ok)  return 4;
                return 0;
            end
            1: return (h_exit || !sol_ok) ? 0 : 1;
            2: return (h_exit || !gh_ok)  ? 0 : 2;
            3: return (c_exit || !am_ok)  ? 0 : 3;
            4: return (c_exit || !gc_ok)  ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int ns;
        bit reload;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pend = 0; m_chg = 0; m_fault = 0;
            c_gh = 0; c_sol = 0; c_amb = 0; c_geo = 0; c_light = 0;
        end else begin
            ns = m_state;
            reload = 1'b0;
`ifdef CLIMATE_FAULT_EN
            if (m_pend != 0 && (c_gh == -128 || c_sol == -128 || c_amb == -128 || c_geo == -128)) begin
                ns = 0;
                reload = 1'b1;
                m_fault = 1;
            end else
`endif
            if (m_pend != 0 && m_cnt == 0) begin
                ns = model_next(m_state);
                m_fault = 0;
            end
            m_chg = (ns != m_state) ? 1 : 0;
            if (m_chg != 0) reload = 1'b1;
            if (reload) m_cnt = DWELL;
            else if (m_cnt > 0) m_cnt--;
            m_state = ns;
            m_pend = sample_valid ? 1 : 0;
            if (sample_valid) begin
                c_gh = gh; c_sol = sol; c_amb = amb; c_geo = geo; c_light = light;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, m_state);
            chk("fan_en", fan_en, m_state != 0);
            chk("solar_pump_en", solar_pump_en, m_state == 1);
            chk("geo_pump_en", geo_pump_en, m_state == 2 || m_state == 4);
            chk("vent_open", vent_open, m_state == 3);
            chk("busy", busy, m_cnt != 0);
            chk("change", change, m_chg);
`ifdef CLIMATE_FAULT_EN
            chk("fault", fault, m_fault);
`endif
        end
    end

    // One-cycle strobe; returns at the negedge after the evaluation edge.
    task automatic send(input int t_gh, input int t_sol, input int t_amb, input int t_geo, input int t_light);
        @(negedge clk);
        gh = 8'(t_gh); sol = 8'(t_sol); amb = 8'(t_amb); geo = 8'(t_geo); light = 16'(t_light);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_fan", fan_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_change", change, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        send(10, 40, 5, 12, 3000);
        chk("heat_solar_state", state, 1);
        chk("heat_solar_pump", solar_pump_en, 1);
        chk("heat_solar_fan", fan_en, 1);
        chk("heat_solar_change", change, 1);
        idle(1);
        chk("change_one_cycle", change, 0);
        idle(3);

        send(10, 40, 5, 20, 2000);
        chk("solar_lost_idle", state, 0);
        idle(4);
        send(10, 40, 5, 20, 2000);
        chk("heat_geo_state", state, 2);
        chk("heat_geo_pump", geo_pump_en, 1);
        idle(4);
        send(18, 40, 5, 20, 2000);
        chk("heat_geo_exit", state, 0);
        idle(4);

        send(10, 40, 5, 12, 2550);
        chk("light_eq_th", state, 1);
        idle(4);
        send(17, 40, 5, 12, 3000);
        chk("hyst_stay", state, 1);
        chk("hyst_stay_change", change, 0);
        idle(1);
        send(18, 40, 5, 12, 3000);
        chk("hyst_exit", state, 0);
        chk("hyst_exit_pump", solar_pump_en, 0);
        chk("hyst_exit_fan", fan_en, 0);
        idle(4);

        send(16, 40, 5, 12, 3000);
        chk("gh_eq_heat_th", state, 0);
        idle(1);
        send(40, 40, 30, 20, 3000);
        chk("cool_amb_state", state, 3);
        chk("cool_amb_vent", vent_open, 1);
        idle(4);
        send(34, 40, 30, 20, 3000);
        chk("cool_hyst_stay", state, 3);
        idle(1);
        send(33, 40, 30, 20, 3000);
        chk("cool_hyst_exit", state, 0);
        idle(4);

        send(40, 40, 36, 20, 3000);
        chk("cool_geo_state", state, 4);
        chk("cool_geo_pump", geo_pump_en, 1);
        send(10, 40, 5, 20, 3000);
        chk("busy_ignored", state, 4);
        chk("busy_mid_dwell", busy, 1);

        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;

        @(negedge clk);
        gh = 8'sd10; sol = 8'sd40; amb = 8'sd5; geo = 8'sd12; light = 16'd3000;
        sample_valid = 1'b1;
        @(negedge clk);
        gh = 8'sd40;
        @(negedge clk);
        sample_valid = 1'b0;
        idle(2);
        chk("back_to_back", state, 1);
        idle(4);
        send(18, 40, 5, 12, 3000);
        idle(4);

        send(-128, 40, 5, 12, 3000);
`ifdef CLIMATE_FAULT_EN
        chk("fault_code_state", state, 0);
        chk("fault_code_flag", fault, 1);
        idle(4);
        send(10, 40, 5, 12, 3000);
        chk("fault_clear", fault, 0);
        send(10, 40, -128, 12, 3000);
        chk("fault_busy_state", state, 0);
        chk("fault_busy_flag", fault, 1);
        idle(4);
        send(10, 40, 5, 12, 3000);
        chk("fault_clean", fault, 0);
`else
        chk("neg128_ordinary", state, 1);
`endif
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
